keypad_scanner: RTL and testbench

//  Keypad reader for the 4x3 matrix keypad on the GameManager board.
//  - Drives KEY_ROW one-hot and samples KEY_COL for each row.
//  - Debounces the key seen across whole scan frames.
//  - Emits one key_valid pulse per press with a 4-bit key code.
//  - Feeds key_inp to the GameManager FSM; runs on the 1 MHz clk_2 domain.

---
 rtl/keypad_if.sv | 25 ++
 rtl/keypad_scanner.sv | 177 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_if.sv
// Signal bundle between the 4x3 keypad scanner and its keypad/consumer side.
// The master modport is the scanner; the slave modport is the keypad matrix and key consumer.
interface keypad_if;
  logic [2:0] KEY_COL;
  logic [3:0] KEY_ROW;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  KEY_COL,
    output KEY_ROW,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output KEY_COL,
    input  KEY_ROW,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// Row-scanning 4x3 keypad reader with whole-frame debounce and one key_valid pulse per press.
// Define KEYPAD_REPEAT_EN to add auto-repeat pulses every REP_FRAMES frames while held.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned DEB_FRAMES = 4,
  parameter int unsigned REP_FRAMES = 125
) (
  input logic      clk_2,
  input logic      rst_n,
  keypad_if.master kp
);
  localparam int unsigned SlotW  = $clog2(SCAN_DIV);
  // The frame counter doubles as the repeat counter while a key is held.
  localparam int unsigned CntMax = (DEB_FRAMES > REP_FRAMES) ? DEB_FRAMES : REP_FRAMES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0]  DebMax   = CntW'(DEB_FRAMES);
`ifdef KEYPAD_REPEAT_EN
  localparam logic [CntW-1:0]  RepMax   = CntW'(REP_FRAMES);
`endif
  localparam logic [3:0] CodeNone = 4'hF;

  typedef enum logic [1:0] {StIdle, StDeb, StPress, StRel} state_e;

  logic [SlotW-1:0] slot_q;
  logic [1:0]       row_q;
  logic [2:0]       col_s1_q, col_s2_q;
  logic [1:0]       keys_q;
  logic [3:0]       code_q;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [3:0]       cand_q;

  logic       sample, frame_end;
  logic [1:0] row_keys;
  logic [2:0] key_sum;
  logic [3:0] frame_code, result;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [2:0] col);
    logic [1:0] c;
    if (col[0])      c = 2'd0;
    else if (col[1]) c = 2'd1;
    else if (col[2]) c = 2'd2;
    else             c = 2'd0;
    if (row == 2'd3) begin
      unique case (c)
        2'd0:    key_map = 4'hA;
        2'd1:    key_map = 4'h0;
        default: key_map = 4'hB;
      endcase
    end else begin
      key_map = {2'b00, row} * 4'd3 + {2'b00, c} + 4'd1;
    end
  endfunction

  always_comb begin
    sample     = (slot_q == SlotLast);
    frame_end  = sample && (row_q == 2'd3);
    row_keys   = {1'b0, col_s2_q[0]} + {1'b0, col_s2_q[1]} + {1'b0, col_s2_q[2]};
    key_sum    = {1'b0, keys_q} + {1'b0, row_keys};
    frame_code = (row_keys != 2'd0) ? key_map(row_q, col_s2_q) : code_q;
    // Ghosting or chords (two or more keys in one frame) read as no key.
    result     = (key_sum == 3'd1) ? frame_code : CodeNone;
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      slot_q     <= '0;
      row_q      <= 2'd0;
      kp.KEY_ROW <= 4'b0001;
      col_s1_q   <= 3'b000;
      col_s2_q   <= 3'b000;
      keys_q     <= 2'd0;
      code_q     <= CodeNone;
    end else begin
      col_s1_q <= kp.KEY_COL;
      col_s2_q <= col_s1_q;
      if (sample) begin
        slot_q     <= '0;
        row_q      <= row_q + 2'd1;
        kp.KEY_ROW <= {kp.KEY_ROW[2:0], kp.KEY_ROW[3]};
        if (frame_end) begin
          keys_q <= 2'd0;
          code_q <= CodeNone;
        end else begin
          keys_q <= (key_sum > 3'd2) ? 2'd2 : key_sum[1:0];
          code_q <= frame_code;
        end
      end else begin
        slot_q <= slot_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      cand_q       <= CodeNone;
      kp.key_code  <= CodeNone;
      kp.key_valid <= 1'b0;
      kp.key_held  <= 1'b0;
    end else begin
      kp.key_valid <= 1'b0;
      if (frame_end) begin
        unique case (state_q)
          StIdle: begin
            if (result != CodeNone) begin
              cand_q <= result;
              if (DEB_FRAMES == 1) begin
                state_q      <= StPress;
                cnt_q        <= '0;
                kp.key_code  <= result;
                kp.key_valid <= 1'b1;
                kp.key_held  <= 1'b1;
              end else begin
                state_q <= StDeb;
                cnt_q   <= CntW'(1);
              end
            end
          end
          StDeb: begin
            if (result == cand_q) begin
              if (cnt_q + 1'b1 == DebMax) begin
                state_q      <= StPress;
                cnt_q        <= '0;
                kp.key_code  <= cand_q;
                kp.key_valid <= 1'b1;
                kp.key_held  <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end else if (result == CodeNone) begin
              state_q <= StIdle;
            end else begin
              cand_q <= result;
              cnt_q  <= CntW'(1);
            end
          end
          StPress: begin
            if (result == cand_q) begin
`ifdef KEYPAD_REPEAT_EN
              if (cnt_q + 1'b1 == RepMax) begin
                cnt_q        <= '0;
                kp.key_valid <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
`else
              state_q <= StPress;
`endif
            end else if (DEB_FRAMES == 1) begin
              state_q     <= StIdle;
              kp.key_held <= 1'b0;
            end else begin
              state_q <= StRel;
              cnt_q   <= CntW'(1);
            end
          end
          StRel: begin
            if (result == cand_q) begin
              state_q <= StPress;
              cnt_q   <= '0;
            end else if (cnt_q + 1'b1 == DebMax) begin
              state_q     <= StIdle;
              kp.key_held <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: frame-level debounce model compared every cycle,
// plus directed press scenarios with literal pulse counts and codes.
module tb_keypad_scanner;
  localparam int unsigned SD = 4;
  localparam int unsigned DF = 2;
  localparam int unsigned RF = 3;
  localparam int FrameCyc = 4 * SD;

  localparam logic [11:0] KN = 12'h000;
  localparam logic [11:0] K1 = 12'h001;
  localparam logic [11:0] K2 = 12'h002;
  localparam logic [11:0] K5 = 12'h010;
  localparam logic [11:0] K7 = 12'h040;
  localparam logic [11:0] K9 = 12'h100;
  localparam logic [11:0] KS = 12'h200;
  localparam logic [11:0] K0 = 12'h400;
  localparam logic [11:0] KH = 12'h800;

`ifdef KEYPAD_REPEAT_EN
  localparam bit RepEn = 1'b1;
`else
  localparam bit RepEn = 1'b0;
`endif

  logic clk_2 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_2 = ~clk_2;

  keypad_if kp();

  keypad_scanner #(
    .SCAN_DIV  (SD),
    .DEB_FRAMES(DF),
    .REP_FRAMES(RF)
  ) dut (
    .clk_2(clk_2),
    .rst_n(rst_n),
    .kp   (kp)
  );

  // Pressed set: bit r*3+c is the key at row r, column c.
  logic [11:0] pressed = KN;

  always_comb begin
    kp.KEY_COL = 3'b000;
    for (int r = 0; r < 4; r++) begin
      if (kp.KEY_ROW[r]) kp.KEY_COL = kp.KEY_COL | pressed[r*3 +: 3];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Frame-level model: runs of identical single-key frames accept a press,
  // runs of non-matching frames release it.
  int          cyc = 0;
  logic [3:0]  e_code = 4'hF;
  logic        e_valid = 1'b0;
  logic        e_held = 1'b0;
  bit          m_held = 1'b0;
  logic [3:0]  m_held_code = 4'hF;
  logic [3:0]  m_run_code = 4'hF;
  int          m_run = 0;
  int          m_miss = 0;
  int          m_rep = 0;

  function automatic logic [3:0] frame_result(input logic [11:0] p);
    logic [3:0] code;
    code = 4'hF;
    if ($countones(p) != 1) return 4'hF;
    for (int i = 0; i < 12; i++) begin
      if (p[i]) begin
        if (i < 9)       code = 4'(i + 1);
        else if (i == 9) code = 4'hA;
        else if (i == 10) code = 4'h0;
        else             code = 4'hB;
      end
    end
    return code;
  endfunction

  task automatic model_frame(input logic [3:0] r);
    if (!m_held) begin
      if (r == 4'hF) m_run = 0;
      else if (m_run > 0 && r == m_run_code) m_run++;
      else begin
        m_run_code = r;
        m_run = 1;
      end
      if (m_run == DF) begin
        m_held = 1'b1; m_held_code = r; e_code = r; e_valid = 1'b1; e_held = 1'b1;
        m_miss = 0; m_rep = 0; m_run = 0;
      end
    end else if (r == m_held_code) begin
      if (m_miss == 0) begin
        if (RepEn) begin
          m_rep++;
          if (m_rep == RF) begin
            e_valid = 1'b1;
            m_rep = 0;
          end
        end
      end else begin
        m_miss = 0;
        m_rep = 0;
      end
    end else begin
      m_miss++;
      m_rep = 0;
      if (m_miss == DF) begin
        m_held = 1'b0; e_held = 1'b0; m_run = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk_2 or negedge rst_n);
    if (!rst_n) begin
      cyc = 0; e_code = 4'hF; e_valid = 1'b0; e_held = 1'b0;
      m_held = 1'b0; m_run = 0; m_miss = 0; m_rep = 0; m_run_code = 4'hF;
    end else begin
      cyc++;
      e_valid = 1'b0;
      if (cyc % FrameCyc == 0) model_frame(frame_result(pressed));
    end
  end

  // Compare process: every cycle, mid-period.
  initial forever begin
    logic [3:0] e_row;
    @(negedge clk_2);
    e_row = 4'b0001 << ((cyc / SD) % 4);
    check("key_row",   32'(kp.KEY_ROW),   32'(e_row));
    check("key_code",  32'(kp.key_code),  32'(e_code));
    check("key_valid", 32'(kp.key_valid), 32'(e_valid));
    check("key_held",  32'(kp.key_held),  32'(e_held));
  end

  // Pulse log for the directed scenario checks.
  int         n_pulses = 0;
  logic [3:0] pulse_code [64];
  time        pulse_t [64];

  initial forever begin
    @(posedge clk_2);
    #2;
    if (rst_n && kp.key_valid === 1'b1 && n_pulses < 64) begin
      pulse_code[n_pulses] = kp.key_code;
      pulse_t[n_pulses] = $time;
      n_pulses++;
    end
  end

  task automatic hold(input logic [11:0] set, input int n);
    pressed = set;
    repeat (FrameCyc * n) @(negedge clk_2);
  endtask

  initial begin
    int base;
    int per;
    per = RepEn ? 2 : 1;

    // 1: reset values and row rotation
    @(negedge clk_2);
    @(negedge clk_2);
    #2 rst_n = 1'b1;
    check("rst_row",   32'(kp.KEY_ROW),   32'h1);
    check("rst_code",  32'(kp.key_code),  32'hF);
    check("rst_valid", 32'(kp.key_valid), 32'h0);
    check("rst_held",  32'(kp.key_held),  32'h0);
    repeat (4) @(negedge clk_2);
    check("rot_row1", 32'(kp.KEY_ROW), 32'h2);
    repeat (4) @(negedge clk_2);
    check("rot_row2", 32'(kp.KEY_ROW), 32'h4);
    repeat (4) @(negedge clk_2);
    check("rot_row3", 32'(kp.KEY_ROW), 32'h8);
    repeat (4) @(negedge clk_2);
    check("rot_wrap", 32'(kp.KEY_ROW), 32'h1);
    hold(KN, 1);

    // 2: hold '2' for 10 frames, then release
    base = n_pulses;
    hold(K2, 3);
    check("s2_first_pulse", 32'(n_pulses - base), 32'd1);
    check("s2_code", 32'(pulse_code[base]), 32'h2);
    hold(K2, 7);
    check("s2_total", 32'(n_pulses - base), RepEn ? 32'd3 : 32'd1);
    check("s2_held", 32'(kp.key_held), 32'h1);
    hold(KN, 3);
    check("s2_released", 32'(kp.key_held), 32'h0);
    check("s2_code_kept", 32'(kp.key_code), 32'h2);

    // 3: '#', '0', '*' in turn
    base = n_pulses;
    hold(KH, 5); hold(KN, 5);
    hold(K0, 5); hold(KN, 5);
    hold(KS, 5); hold(KN, 5);
    check("s3_count", 32'(n_pulses - base), 32'(3 * per));
    check("s3_code_hash", 32'(pulse_code[base]), 32'hB);
    check("s3_code_zero", 32'(pulse_code[base + per]), 32'h0);
    check("s3_code_star", 32'(pulse_code[base + 2 * per]), 32'hA);

    // 4: bouncing '5', then chord '1'+'5'
    base = n_pulses;
    for (int i = 0; i < 4; i++) begin
      hold(K5, 1);
      hold(KN, 1);
    end
    check("s4_bounce", 32'(n_pulses - base), 32'd0);
    hold(K1 | K5, 6);
    check("s4_chord", 32'(n_pulses - base), 32'd0);
    check("s4_chord_held", 32'(kp.key_held), 32'h0);
    hold(KN, 1);

    // 5: reset during debounce of '7'
    hold(K7, 1);
    repeat (5) @(negedge clk_2);
    #2 rst_n = 1'b0;
    #1;
    check("s5_rst_code", 32'(kp.key_code), 32'hF);
    check("s5_rst_row",  32'(kp.KEY_ROW),  32'h1);
    check("s5_rst_held", 32'(kp.key_held), 32'h0);
    base = n_pulses;
    repeat (2) @(negedge clk_2);
    #2 rst_n = 1'b1;
    hold(K7, 6);
    check("s5_count", 32'(n_pulses - base), 32'(per));
    check("s5_code", 32'(pulse_code[base]), 32'h7);
    hold(KN, 3);

    // 6: '9' held 12 frames
    base = n_pulses;
    hold(K9, 12);
    check("s6_count", 32'(n_pulses - base), RepEn ? 32'd4 : 32'd1);
    check("s6_code", 32'(pulse_code[base]), 32'h9);
    if (RepEn) begin
      check("s6_rep_period", 32'(pulse_t[base + 1] - pulse_t[base]), 32'd480);
      check("s6_rep_code", 32'(pulse_code[base + 1]), 32'h9);
    end
    hold(KN, 3);
    check("s6_released", 32'(kp.key_held), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d checks", checks);
    $fatal(1, "watchdog");
  end
endmodule
